mdu_unit: RTL and testbench

- Multiply/divide unit for the 5-stage pipelined `mips` core. It owns the HI/LO registers.
- The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to it.
- The hazard unit stalls on `busy`. ID/EX reads `hi`/`lo` for MFHI/MFLO.
- Multicycle and fixed-latency, so bench timing is deterministic.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_divider.sv | 45 ++++
 rtl/mdu_unit.sv | 134 +++++++++++++
 tb/tb_mdu_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and the
// divide-by-zero quotient, plus a small two's-complement magnitude helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // Negate when requested; used both to take magnitudes and to restore signs.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit signed/unsigned restoring divider with sign fix-up and
// the divide-by-zero rule; the top module supplies the fixed latency.
module mdu_divider
    import mdu_pkg::*;
(
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_q;
    logic [32:0] part;

    always_comb begin
        neg_a = is_signed & dividend[31];
        neg_b = is_signed & divisor[31];
        mag_a = cond_neg(dividend, neg_a);
        mag_b = cond_neg(divisor, neg_b);
        part  = '0;
        mag_q = '0;
        // One shift-subtract step per quotient bit, MSB first.
        for (int i = 31; i >= 0; i--) begin
            part = {part[31:0], mag_a[i]};
            if (part >= {1'b0, mag_b}) begin
                part     = part - {1'b0, mag_b};
                mag_q[i] = 1'b1;
            end
        end
        // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0 naturally.
        if (divisor == 32'd0) begin
            quotient  = DIV0_QUOT;
            remainder = dividend;
        end else begin
            quotient  = cond_neg(mag_q, neg_a ^ neg_b);
            remainder = cond_neg(part[31:0], neg_a);
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit owning HI/LO with fixed MUL_CYCLES/DIV_CYCLES latency.
// Optional MDU_FLUSH_EN adds a flush input that squashes the op in flight.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

    mdu_divider u_divider (
        .dividend  (a_q),
        .divisor   (b_q),
        .is_signed (sgn_q),
        .quotient  (quot),
        .remainder (rem)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            state_d = ST_MUL;
                            count_d = MUL_LOAD;
                            a_d     = src_a;
                            b_d     = src_b;
                            sgn_d   = (op == MDU_MULT);
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state_d = ST_DIV;
                            count_d = DIV_LOAD;
                            a_d     = src_a;
                            b_d     = src_b;
                            sgn_d   = (op == MDU_DIV);
                        end
                        MDU_MTHI: hi_d = src_a;
                        MDU_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                // Any start while busy is dropped; the pipeline is stalled anyway.
                if (count_q == 6'd1) begin
                    state_d = ST_IDLE;
                    count_d = 6'd0;
                    if (state_q == ST_MUL) begin
                        {hi_d, lo_d} = prod;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 6'd0;
            end
        endcase
`ifdef MDU_FLUSH_EN
        if (flush) begin
            state_d = ST_IDLE;
            count_d = 6'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected HI/LO/latency pushed at issue,
// popped and compared when busy falls.
module tb_mdu_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_FLUSH_EN
    logic        flush = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    mdu_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MDU_FLUSH_EN
        .flush (flush),
`endif
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        int     ia, ib, q, r;
        longint sa, sb;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        case (o)
            3'd0: return sa * sb;
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int cyc);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    // Returns at the negedge after the accepting edge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int seen);
        int   n;
        int   guard;
        exp_t e;
        n     = seen;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
            if (busy) n++;
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_lat"}, 32'(n), 32'(e.cyc));
            chk({tag, "_hi"}, hi, e.hi);
            chk({tag, "_lo"}, lo, e.lo);
        end
    endtask

    initial begin
        logic [63:0] m;
        logic [2:0]  ro;
        logic [31:0] ra, rb, hold_hi, hold_lo;

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_N);
        start_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        finish_op("mult_neg", busy ? 1 : 0);

        push(32'hFFFF_FFFE, 32'h0000_0001, MUL_N);
        start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", busy ? 1 : 0);

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
        start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg", busy ? 1 : 0);

        push(32'd100, 32'hFFFF_FFFF, DIV_N);
        start_op(3'd3, 32'd100, 32'd0);
        finish_op("divu_zero", busy ? 1 : 0);

        push(32'd0, 32'h8000_0000, DIV_N);
        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", busy ? 1 : 0);

        // MTHI then MTLO back to back.
        @(negedge clk);
        op = 3'd4; src_a = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        op = 3'd5; src_a = 32'hCAFE_BABE;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", lo, 32'hCAFE_BABE);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);

        // MULT with an MTLO and operand changes arriving while busy.
        push(32'd0, 32'd42, MUL_N);
        start_op(3'd0, 32'd7, 32'd6);
        chk("mult_ign_busy", {31'd0, busy}, 32'd1);
        op = 3'd5; src_a = 32'd0; src_b = 32'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_a = 32'd1000;
        finish_op("mult_ign", busy ? 2 : 0);

        // Reserved op codes leave everything alone.
        hold_hi = 32'd0;
        hold_lo = 32'd42;
        start_op(3'd6, 32'hDEAD_BEEF, 32'd1);
        chk("op6_busy", {31'd0, busy}, 32'd0);
        start_op(3'd7, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        chk("op7_busy", {31'd0, busy}, 32'd0);
        chk("op7_hi", hi, hold_hi);
        chk("op7_lo", lo, hold_lo);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 4) rb = 32'd0;
            m = model(ro, ra, rb);
            push(m[63:32], m[31:0], (ro < 3'd2) ? MUL_N : DIV_N);
            $display("rand op=%0d a=%08h b=%08h", ro, ra, rb);
            start_op(ro, ra, rb);
            finish_op("rand", busy ? 1 : 0);
        end

`ifdef MDU_FLUSH_EN
        hold_hi = hi;
        hold_lo = lo;
        start_op(3'd0, 32'd123, 32'd456);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        repeat (MUL_N + 2) @(negedge clk);
        chk("flush_hi", hi, hold_hi);
        chk("flush_lo", lo, hold_lo);
`endif

        // Reset on cycle 4 of a DIV aborts with no result written.
        start_op(3'd3, 32'd1000, 32'd7);
        repeat (2) @(negedge clk);
        chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        repeat (DIV_N + 2) @(negedge clk);
        chk("rstmid_late_lo", lo, 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
